// File: rtl/ex_result_skid_pkg.sv
// Shared pipeline types for the EX->MEM result path: the carried entry and the x0 constant.
package riscv_pipe_pkg;

    localparam int unsigned DATA_WIDTH     = 32;
    localparam int unsigned REG_ADDR_WIDTH = 5;
    localparam int unsigned OPCODE_LENGTH  = 4;

    localparam logic [REG_ADDR_WIDTH-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic [DATA_WIDTH-1:0]     result;
        logic [REG_ADDR_WIDTH-1:0] rd;
        logic                      regwrite;
        logic [OPCODE_LENGTH-1:0]  op;
    } ex_result_t;

endpackage

// File: rtl/ex_result_skid_pipe_slot.sv
// One pipeline slot: a valid bit plus payload register, async reset, load/clear enables.
module pipe_slot
    import riscv_pipe_pkg::*;
#(
    parameter type T = ex_result_t
) (
    input  logic clk,
    input  logic rst,
    input  logic load_i,
    input  logic clear_i,
    input  T     data_i,
    output logic valid_o,
    output T     data_o
);

    logic valid_q;
    T     data_q;

    // Clear only drops the valid bit; payload is left as-is so it never toggles needlessly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (clear_i) begin
            valid_q <= 1'b0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            data_q  <= data_i;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/ex_result_skid.sv
// Registered 2-entry skid buffer between the EX-stage ALU and MEM, with head forwarding.
// Optional EX_SKID_STALL_CNT_EN adds a saturating stall_cnt output.
module ex_result_skid #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned REG_ADDR_WIDTH = 5,
    parameter int unsigned OPCODE_LENGTH  = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DATA_WIDTH-1:0]     in_result,
    input  logic [REG_ADDR_WIDTH-1:0] in_rd,
    input  logic                      in_regwrite,
    input  logic [OPCODE_LENGTH-1:0]  in_op,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_WIDTH-1:0]     out_result,
    output logic [REG_ADDR_WIDTH-1:0] out_rd,
    output logic                      out_regwrite,
    output logic [OPCODE_LENGTH-1:0]  out_op,
    output logic                      fwd_valid,
    output logic [REG_ADDR_WIDTH-1:0] fwd_rd,
    output logic [DATA_WIDTH-1:0]     fwd_result
`ifdef EX_SKID_STALL_CNT_EN
    ,
    output logic [31:0]               stall_cnt
`endif
);

    import riscv_pipe_pkg::*;

    typedef struct packed {
        logic [DATA_WIDTH-1:0]     result;
        logic [REG_ADDR_WIDTH-1:0] rd;
        logic                      regwrite;
        logic [OPCODE_LENGTH-1:0]  op;
    } entry_t;

    entry_t in_entry;
    entry_t head_d;
    entry_t head_q;
    entry_t skid_q;
    logic   head_valid;
    logic   skid_valid;
    logic   head_load;
    logic   head_clear;
    logic   skid_load;
    logic   skid_clear;
    logic   in_fire;
    logic   out_fire;

    // Writes to x0 are kept for the result value but never enable write-back.
    always_comb begin
        in_entry.result   = in_result;
        in_entry.rd       = in_rd;
        in_entry.regwrite = in_regwrite && (in_rd != REG_ZERO);
        in_entry.op       = in_op;
    end

    assign in_ready = ~skid_valid;
    assign in_fire  = in_valid & in_ready;
    assign out_fire = head_valid & out_ready;

    always_comb begin
        head_load  = 1'b0;
        head_clear = 1'b0;
        skid_load  = 1'b0;
        skid_clear = 1'b0;
        head_d     = in_entry;
        if (flush) begin
            head_clear = 1'b1;
            skid_clear = 1'b1;
        end else if (skid_valid) begin
            if (out_fire) begin
                head_load  = 1'b1;
                head_d     = skid_q;
                skid_clear = 1'b1;
            end
        end else if (!head_valid) begin
            head_load = in_fire;
        end else if (out_fire) begin
            head_load  = in_fire;
            head_clear = ~in_fire;
        end else begin
            skid_load = in_fire;
        end
    end

    pipe_slot #(.T(entry_t)) u_head (
        .clk     (clk),
        .rst     (reset),
        .load_i  (head_load),
        .clear_i (head_clear),
        .data_i  (head_d),
        .valid_o (head_valid),
        .data_o  (head_q)
    );

    pipe_slot #(.T(entry_t)) u_skid (
        .clk     (clk),
        .rst     (reset),
        .load_i  (skid_load),
        .clear_i (skid_clear),
        .data_i  (in_entry),
        .valid_o (skid_valid),
        .data_o  (skid_q)
    );

    assign out_valid    = head_valid;
    assign out_result   = head_q.result;
    assign out_rd       = head_q.rd;
    assign out_regwrite = head_q.regwrite;
    assign out_op       = head_q.op;

    assign fwd_valid  = head_valid & head_q.regwrite & (head_q.rd != REG_ZERO);
    assign fwd_rd     = head_q.rd;
    assign fwd_result = head_q.result;

`ifdef EX_SKID_STALL_CNT_EN
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= '0;
        end else if (head_valid && !out_ready && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_ex_result_skid.sv
// Randomized bench for ex_result_skid against a queue model, plus directed literal checks.
module tb_ex_result_skid;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_result;
    logic [4:0]  in_rd;
    logic        in_regwrite;
    logic [3:0]  in_op;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [4:0]  out_rd;
    logic        out_regwrite;
    logic [3:0]  out_op;
    logic        fwd_valid;
    logic [4:0]  fwd_rd;
    logic [31:0] fwd_result;
`ifdef EX_SKID_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    always #5 clk = ~clk;

    ex_result_skid #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5), .OPCODE_LENGTH(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_result    (in_result),
        .in_rd        (in_rd),
        .in_regwrite  (in_regwrite),
        .in_op        (in_op),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_result   (out_result),
        .out_rd       (out_rd),
        .out_regwrite (out_regwrite),
        .out_op       (out_op),
        .fwd_valid    (fwd_valid),
        .fwd_rd       (fwd_rd),
        .fwd_result   (fwd_result)
`ifdef EX_SKID_STALL_CNT_EN
        ,
        .stall_cnt    (stall_cnt)
`endif
    );

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        logic        rw;
        logic [3:0]  op;
    } ent_t;

    ent_t        q[$];
    logic [31:0] mcnt;
    int          n_cmp = 0;
    int          n_err = 0;
    bit          chk_on = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: the buffer is a FIFO of depth 2; ready means fewer than 2 entries held.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            q.delete();
            mcnt = 32'd0;
        end else begin
            bit   ifire, ofire;
            ent_t e;
            ifire = in_valid && (q.size() < 2);
            ofire = (q.size() > 0) && out_ready;
            if ((q.size() > 0) && !out_ready && (mcnt != 32'hFFFF_FFFF)) mcnt = mcnt + 32'd1;
            if (flush) begin
                q.delete();
            end else begin
                if (ofire) void'(q.pop_front());
                if (ifire) begin
                    e.res = in_result;
                    e.rd  = in_rd;
                    e.rw  = in_regwrite && (in_rd != 5'd0);
                    e.op  = in_op;
                    q.push_back(e);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on && !reset) begin
            check("m_out_valid", out_valid, q.size() > 0);
            check("m_in_ready", in_ready, q.size() < 2);
            if (q.size() > 0) begin
                check("m_out_result", out_result, q[0].res);
                check("m_out_rd", out_rd, q[0].rd);
                check("m_out_regwrite", out_regwrite, q[0].rw);
                check("m_out_op", out_op, q[0].op);
                check("m_fwd_valid", fwd_valid, q[0].rw && (q[0].rd != 5'd0));
                check("m_fwd_rd", fwd_rd, q[0].rd);
                check("m_fwd_result", fwd_result, q[0].res);
            end else begin
                check("m_fwd_valid_empty", fwd_valid, 1'b0);
            end
`ifdef EX_SKID_STALL_CNT_EN
            check("m_stall_cnt", stall_cnt, mcnt);
`endif
        end
    end

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic [31:0] r, input logic [4:0] rd,
                         input logic rw, input logic [3:0] op);
        in_valid    = v;
        in_result   = r;
        in_rd       = rd;
        in_regwrite = rw;
        in_op       = op;
    endtask

    initial begin
        reset = 1'b1;
        flush = 1'b0;
        out_ready = 1'b0;
        drive(1'b0, 32'd0, 5'd0, 1'b0, 4'd0);
        repeat (3) @(negedge clk);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_fwd_valid", fwd_valid, 1'b0);
        check("rst_out_fields", {out_result, out_rd, out_regwrite, out_op}, 64'd0);
        reset = 1'b0;
        chk_on = 1'b1;
        @(negedge clk);
        check("rel_out_valid", out_valid, 1'b0);
        check("rel_in_ready", in_ready, 1'b1);

        // Streaming with no backpressure.
        out_ready = 1'b1;
        drive(1'b1, 32'h0000_000F, 5'd5, 1'b1, 4'd3);
        cyc();
        check("str1_result", out_result, 32'h0000_000F);
        check("str1_rd", out_rd, 5'd5);
        check("str1_fwd_valid", fwd_valid, 1'b1);
        check("str1_in_ready", in_ready, 1'b1);
        drive(1'b1, 32'h0000_00FF, 5'd6, 1'b1, 4'd2);
        cyc();
        check("str2_result", out_result, 32'h0000_00FF);
        check("str2_valid", out_valid, 1'b1);
        check("str2_in_ready", in_ready, 1'b1);
        drive(1'b0, 32'd0, 5'd0, 1'b0, 4'd0);
        cyc();
        check("str_drain", out_valid, 1'b0);

        // Backpressure: two accepted, third refused, then drained in order.
        out_ready = 1'b0;
        drive(1'b1, 32'h0000_000A, 5'd1, 1'b1, 4'd1);
        cyc();
        check("bp1_result", out_result, 32'h0000_000A);
        check("bp1_in_ready", in_ready, 1'b1);
        drive(1'b1, 32'h0000_0005, 5'd2, 1'b1, 4'd1);
        cyc();
        check("bp2_in_ready", in_ready, 1'b0);
        check("bp2_result", out_result, 32'h0000_000A);
        drive(1'b1, 32'h0000_0077, 5'd3, 1'b1, 4'd1);
        cyc();
        check("bp3_in_ready", in_ready, 1'b0);
        check("bp3_result", out_result, 32'h0000_000A);
        drive(1'b0, 32'd0, 5'd0, 1'b0, 4'd0);
        out_ready = 1'b1;
        cyc();
        check("bp4_result", out_result, 32'h0000_0005);
        check("bp4_in_ready", in_ready, 1'b1);
        cyc();
        check("bp5_empty", out_valid, 1'b0);

        // x0 destination.
        drive(1'b1, 32'hDEAD_BEEF, 5'd0, 1'b1, 4'd7);
        cyc();
        check("x0_regwrite", out_regwrite, 1'b0);
        check("x0_fwd_valid", fwd_valid, 1'b0);
        check("x0_result", out_result, 32'hDEAD_BEEF);
        drive(1'b0, 32'd0, 5'd0, 1'b0, 4'd0);
        cyc();

        // Flush with both entries full and a new input presented.
        out_ready = 1'b0;
        drive(1'b1, 32'h0000_0011, 5'd9, 1'b1, 4'd4);
        cyc();
        drive(1'b1, 32'h0000_0022, 5'd10, 1'b1, 4'd4);
        cyc();
        check("fl_full", in_ready, 1'b0);
        flush = 1'b1;
        drive(1'b1, 32'h0000_0099, 5'd11, 1'b1, 4'd4);
        cyc();
        flush = 1'b0;
        drive(1'b0, 32'd0, 5'd0, 1'b0, 4'd0);
        check("fl_out_valid", out_valid, 1'b0);
        check("fl_in_ready", in_ready, 1'b1);
        out_ready = 1'b1;
        cyc();
        check("fl_no_ghost", out_valid, 1'b0);

        // Async reset mid-cycle with the head full.
        #2 reset = 1'b1;
        #1 reset = 1'b0;
        @(negedge clk);
        out_ready = 1'b0;
        drive(1'b1, 32'h0000_1234, 5'd7, 1'b1, 4'd5);
        cyc();
        drive(1'b0, 32'd0, 5'd0, 1'b0, 4'd0);
        repeat (3) cyc();
        check("ar_pre_valid", out_valid, 1'b1);
`ifdef EX_SKID_STALL_CNT_EN
        check("ar_pre_stall", stall_cnt, 32'd3);
`endif
        #2 reset = 1'b1;
        #1;
        check("ar_out_valid", out_valid, 1'b0);
        check("ar_in_ready", in_ready, 1'b1);
`ifdef EX_SKID_STALL_CNT_EN
        check("ar_stall", stall_cnt, 32'd0);
`endif
        @(negedge clk);
        reset = 1'b0;

        // Random traffic checked against the queue model every cycle.
        for (int i = 0; i < 3000; i++) begin
            flush     = ($urandom_range(0, 15) == 0);
            out_ready = ($urandom_range(0, 2) != 0);
            drive($urandom_range(0, 3) != 0, $urandom,
                  ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom),
                  1'($urandom), 4'($urandom));
            cyc();
        end
        flush = 1'b0;
        drive(1'b0, 32'd0, 5'd0, 1'b0, 4'd0);
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ex_result_skid.md
Name: ex_result_skid

Overview:
- Registered 2-entry skid buffer between the EX-stage ALU, whose OR/AND/ADD result feeds `in_result`, and the MEM stage.
- Carries the ALU result plus destination-register metadata across a valid/ready handshake.
- Absorbs one cycle of MEM backpressure without a combinational ready path.
- Exports the head entry for EX-stage forwarding.

Parameters:
- DATA_WIDTH, 32, width of ALU result
- REG_ADDR_WIDTH, 5, destination register index width
- OPCODE_LENGTH, 4, width of the ALU opcode tag carried with the result

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  asynchronous, active-high reset
- flush  input  1  synchronous kill of all held entries (branch mispredict)
- in_valid  input  1  ALU result valid
- in_ready  output  1  buffer can accept; registered
- in_result  input  DATA_WIDTH  ALU result (Rd of ALU op)
- in_rd  input  REG_ADDR_WIDTH  destination register
- in_regwrite  input  1  write-back enable
- in_op  input  OPCODE_LENGTH  ALU opcode tag
- out_valid  output  1  head entry valid
- out_ready  input  1  MEM stage accepts
- out_result  output  DATA_WIDTH  head result
- out_rd  output  REG_ADDR_WIDTH  head destination
- out_regwrite  output  1  head write-back enable
- out_op  output  OPCODE_LENGTH  head opcode tag
- fwd_valid  output  1  head is forwardable
- fwd_rd  output  REG_ADDR_WIDTH  forwarding destination
- fwd_result  output  DATA_WIDTH  forwarding value

Behaviour:
- Storage: head register (drives out_*) and skid register, each with its own valid bit.
- Reset (async): head_valid=0, skid_valid=0, in_ready=1, all data/rd/op/regwrite fields=0.
- Fire conditions: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- in_ready = !skid_valid, taken from a flop, never from out_ready.
- Latency: an accepted entry appears on out_* the next cycle when the head is empty or firing.
- Head empty, in_fire: head <= input; head_valid=1.
- Head full, out_fire, skid empty, in_fire: head <= input. No bubble.
- Head full, out_fire, skid empty, no in_fire: head_valid=0.
- Head full, !out_ready, in_fire: skid <= input; in_ready=0 next cycle.
- Skid full, out_fire: head <= skid; skid_valid=0; in_ready=1 next cycle.
- Skid full, !out_ready: hold all state; no input is accepted because in_ready=0.
- Ordering: strictly FIFO; the skid entry never overtakes the head.
- x0 rule: if in_rd==0, the stored regwrite is forced to 0; the result is still stored.
- flush: at the next edge head_valid=0 and skid_valid=0; an input presented that cycle is dropped. Flush has priority over in_fire and out_fire. The out_fire in the flush cycle still counts as consumed by MEM.
- Data fields are not cleared on flush or pop; only the valid bits change.
- fwd_valid = head_valid & out_regwrite & (out_rd != 0); fwd_rd = out_rd; fwd_result = out_result. All are combinational from the head register.
- Reset mid-transfer: all entries are discarded immediately; out_valid drops asynchronously.

Optional Feature:
- Macro EX_SKID_STALL_CNT_EN.
- Defined:
  - Adds output stall_cnt, 32 bits: counts cycles with out_valid & !out_ready.
  - Saturates at 32'hFFFFFFFF.
  - Cleared by reset; flush does not clear it.
- Undefined: port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Package riscv_pipe_pkg:
  - typedef struct packed ex_result_t {result, rd, regwrite, op}, parameterised through package localparams DATA_WIDTH=32, REG_ADDR_WIDTH=5, OPCODE_LENGTH=4.
  - Constant REG_ZERO='0.
- Sub-module pipe_slot: one valid+payload register with async reset, load and clear enables. Instantiated twice, for head and skid.

Test Plan:
- Reset held, then released -> out_valid=0, in_ready=1, fwd_valid=0, all out_* zero.
- Streaming: out_ready=1; inputs result 32'h0000000F/rd 5, then 32'h000000FF/rd 6, on consecutive cycles -> out_* shows each entry one cycle later, no bubble, in_ready stays 1.
- Backpressure:
  - Stimulus: out_ready=0; push 32'h0000000A/rd 1, then 32'h00000005/rd 2.
  - Response: in_ready=0 after the second accept; a third in_valid is not accepted.
  - Then set out_ready=1: outputs 0x0A then 0x05 in order; in_ready returns to 1.
- x0 write: in_rd=0, in_regwrite=1, result 32'hDEADBEEF -> out_regwrite=0, fwd_valid=0, out_result=32'hDEADBEEF.
- Flush with both entries full and in_valid=1 -> next cycle out_valid=0, in_ready=1, the flushed input never appears.
- Async reset asserted mid-cycle with head full -> out_valid=0 before the next clk edge. With EX_SKID_STALL_CNT_EN defined, 3 stalled cycles beforehand -> stall_cnt=3 before the reset, 0 after.
